risk_gate_param: RTL and testbench

RISK_GATE_PARAM -- requirements
Module: risk_gate_param

---
 rtl/risk_pkg.sv | 19 +
 rtl/risk_table.sv | 70 +++++++
 rtl/risk_gate_param.sv | 145 ++++++++++++++
 tb/tb_risk_gate_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/risk_pkg.sv
// Shared types and default sizing for the pre-trade risk gate.
package risk_pkg;

  localparam int N_CLIENTS_DEF = 32;
  localparam int AMT_W_DEF     = 16;
  localparam int LIM_W_DEF     = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_COMMIT
  } state_t;

  typedef enum logic {
    KIND_ORDER = 1'b0,
    KIND_MAX   = 1'b1
  } ord_kind_t;

endpackage

// File: rtl/risk_table.sv
// Per-client max/accumulated/cancelled storage with a registered read port,
// an order write port and an independent cancel read-modify-write port.
module risk_table
  import risk_pkg::*;
#(
  parameter int N_CLIENTS = N_CLIENTS_DEF,
  parameter int AMT_W     = AMT_W_DEF,
  parameter int LIM_W     = LIM_W_DEF,
  localparam int CID_W    = $clog2(N_CLIENTS)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             rd_en,
  input  logic [CID_W-1:0] rd_client,
  output logic [LIM_W-1:0] rd_max,
  output logic [LIM_W-1:0] rd_acc,
  output logic [LIM_W-1:0] rd_cxl,
  input  logic             wr_en,
  input  logic [CID_W-1:0] wr_client,
  input  logic [LIM_W-1:0] wr_max,
  input  logic [LIM_W-1:0] wr_acc,
  input  logic             cxl_valid,
  input  logic [CID_W-1:0] cxl_client,
  input  logic [AMT_W-1:0] cxl_amount
);

  logic [LIM_W-1:0] max_mem [N_CLIENTS];
  logic [LIM_W-1:0] acc_mem [N_CLIENTS];
  logic [LIM_W-1:0] cxl_mem [N_CLIENTS];

  logic [LIM_W:0]   cxl_sum_wide;
  logic [LIM_W-1:0] cxl_sum;

  assign cxl_sum_wide = {1'b0, cxl_mem[cxl_client]} + (LIM_W + 1)'(cxl_amount);
  assign cxl_sum      = cxl_sum_wide[LIM_W] ? '1 : cxl_sum_wide[LIM_W-1:0];

  // Orders only touch max/acc and cancels only touch cxl, so a commit and a
  // cancel on the same client merge field-wise without losing either update.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        max_mem[i] <= '0;
        acc_mem[i] <= '0;
        cxl_mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        max_mem[wr_client] <= wr_max;
        acc_mem[wr_client] <= wr_acc;
      end
      if (cxl_valid) begin
        cxl_mem[cxl_client] <= cxl_sum;
      end
    end
  end

  // A cancel landing on the same edge as the snapshot is forwarded into it.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_max <= '0;
      rd_acc <= '0;
      rd_cxl <= '0;
    end else if (rd_en) begin
      rd_max <= max_mem[rd_client];
      rd_acc <= acc_mem[rd_client];
      rd_cxl <= (cxl_valid && (cxl_client == rd_client)) ? cxl_sum : cxl_mem[rd_client];
    end
  end

endmodule

// File: rtl/risk_gate_param.sv
// Pre-trade risk gate: checks each order against its client's exposure limit
// in a three-cycle IDLE/CHECK/COMMIT pipeline, with asynchronous-to-FSM cancels.
module risk_gate_param
  import risk_pkg::*;
#(
  parameter int N_CLIENTS = N_CLIENTS_DEF,
  parameter int AMT_W     = AMT_W_DEF,
  parameter int LIM_W     = LIM_W_DEF,
  localparam int CID_W    = $clog2(N_CLIENTS)
) (
  input  logic             clk,
  input  logic             HRESETn,
  input  logic             ord_valid,
  output logic             ord_ready,
  input  logic             ord_kind,
  input  logic [CID_W-1:0] ord_client,
  input  logic [LIM_W-1:0] ord_amount,
  input  logic             cxl_valid,
  input  logic [CID_W-1:0] cxl_client,
  input  logic [AMT_W-1:0] cxl_amount,
  output logic             rsp_valid,
  output logic             rsp_accept,
  output logic [CID_W-1:0] rsp_client,
  output logic [LIM_W-1:0] rsp_exposure
);

  localparam int EW = LIM_W + 2;

  state_t           state_reg, state_next;
  ord_kind_t        kind_reg;
  logic [CID_W-1:0] client_reg;
  logic [LIM_W-1:0] amount_reg;

  logic             commit_en_reg;
  logic [LIM_W-1:0] new_max_reg, new_acc_reg;
  logic             rsp_valid_reg, rsp_accept_reg;
  logic [CID_W-1:0] rsp_client_reg;
  logic [LIM_W-1:0] rsp_exposure_reg;

  logic [LIM_W-1:0] rd_max, rd_acc, rd_cxl;
  logic             handshake;
  logic [AMT_W-1:0] add_term;
  logic [EW-1:0]    expo_raw;
  logic [LIM_W-1:0] expo_sat;
  logic [LIM_W:0]   acc_sum_wide;
  logic [LIM_W-1:0] acc_sat;
  logic             pass;

  assign handshake = ord_valid && ord_ready;

  always_ff @(posedge clk) begin
    if (HRESETn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ord_ready  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ord_ready = 1'b1;
        if (ord_valid) state_next = ST_CHECK;
      end
      ST_CHECK:  state_next = ST_COMMIT;
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (HRESETn) begin
      kind_reg   <= KIND_ORDER;
      client_reg <= '0;
      amount_reg <= '0;
    end else if (handshake) begin
      kind_reg   <= ord_kind_t'(ord_kind);
      client_reg <= ord_client;
      amount_reg <= ord_amount;
    end
  end

  risk_table #(
    .N_CLIENTS(N_CLIENTS),
    .AMT_W    (AMT_W),
    .LIM_W    (LIM_W)
  ) u_table (
    .clk       (clk),
    .srst      (HRESETn),
    .rd_en     (handshake),
    .rd_client (ord_client),
    .rd_max    (rd_max),
    .rd_acc    (rd_acc),
    .rd_cxl    (rd_cxl),
    .wr_en     (commit_en_reg && (state_reg == ST_COMMIT)),
    .wr_client (client_reg),
    .wr_max    (new_max_reg),
    .wr_acc    (new_acc_reg),
    .cxl_valid (cxl_valid),
    .cxl_client(cxl_client),
    .cxl_amount(cxl_amount)
  );

  // A max update reports acc - cxl, i.e. the same formula with no order amount.
  assign add_term     = (kind_reg == KIND_ORDER) ? amount_reg[AMT_W-1:0] : '0;
  assign expo_raw     = EW'(rd_acc) + EW'(add_term) - EW'(rd_cxl);
  assign acc_sum_wide = {1'b0, rd_acc} + (LIM_W + 1)'(add_term);
  assign acc_sat      = acc_sum_wide[LIM_W] ? '1 : acc_sum_wide[LIM_W-1:0];

  always_comb begin
    expo_sat = expo_raw[LIM_W-1:0];
    if (expo_raw[EW-1])            expo_sat = '0;
    else if (|expo_raw[EW-2:LIM_W]) expo_sat = '1;
  end

  assign pass = (kind_reg == KIND_MAX) || (expo_sat <= rd_max);

  always_ff @(posedge clk) begin
    if (HRESETn) begin
      commit_en_reg    <= 1'b0;
      new_max_reg      <= '0;
      new_acc_reg      <= '0;
      rsp_valid_reg    <= 1'b0;
      rsp_accept_reg   <= 1'b0;
      rsp_client_reg   <= '0;
      rsp_exposure_reg <= '0;
    end else if (state_reg == ST_CHECK) begin
      commit_en_reg    <= pass;
      new_max_reg      <= (kind_reg == KIND_MAX) ? amount_reg : rd_max;
      new_acc_reg      <= (kind_reg == KIND_MAX) ? rd_acc : acc_sat;
      rsp_valid_reg    <= 1'b1;
      rsp_accept_reg   <= pass;
      rsp_client_reg   <= client_reg;
      rsp_exposure_reg <= expo_sat;
    end else begin
      commit_en_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid    = rsp_valid_reg;
  assign rsp_accept   = rsp_accept_reg;
  assign rsp_client   = rsp_client_reg;
  assign rsp_exposure = rsp_exposure_reg;

endmodule

// File: tb/tb_risk_gate_param.sv
// Directed, table-driven bench for risk_gate_param with a narrowed limit width
// so the saturation corner is reachable in a few dozen orders.
module tb_risk_gate_param;

  localparam int NC = 8;
  localparam int AW = 16;
  localparam int LW = 20;
  localparam int CW = 3;
  localparam longint ONES = (64'd1 << LW) - 1;

  logic          clk = 1'b0;
  logic          HRESETn;
  logic          ord_valid;
  logic          ord_ready;
  logic          ord_kind;
  logic [CW-1:0] ord_client;
  logic [LW-1:0] ord_amount;
  logic          cxl_valid;
  logic [CW-1:0] cxl_client;
  logic [AW-1:0] cxl_amount;
  logic          rsp_valid;
  logic          rsp_accept;
  logic [CW-1:0] rsp_client;
  logic [LW-1:0] rsp_exposure;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  risk_gate_param #(
    .N_CLIENTS(NC),
    .AMT_W    (AW),
    .LIM_W    (LW)
  ) dut (
    .clk         (clk),
    .HRESETn     (HRESETn),
    .ord_valid   (ord_valid),
    .ord_ready   (ord_ready),
    .ord_kind    (ord_kind),
    .ord_client  (ord_client),
    .ord_amount  (ord_amount),
    .cxl_valid   (cxl_valid),
    .cxl_client  (cxl_client),
    .cxl_amount  (cxl_amount),
    .rsp_valid   (rsp_valid),
    .rsp_accept  (rsp_accept),
    .rsp_client  (rsp_client),
    .rsp_exposure(rsp_exposure)
  );

  typedef struct {
    logic   kind;
    int     client;
    longint amount;
    longint pre_cxl;
    longint mid_cxl;
    int     mid_at;
    logic   exp_acc;
    longint exp_expo;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic pulse_cxl(input int c, input longint amt);
    cxl_valid  = 1'b1;
    cxl_client = CW'(c);
    cxl_amount = AW'(amt);
    @(negedge clk);
    cxl_valid  = 1'b0;
  endtask

  // Issues one request; mid_at selects the post-handshake cycle (1 = CHECK,
  // 2 = COMMIT) in which a cancel on the same client is driven.
  task automatic do_req(input logic k, input int c, input longint amt, input longint mid_cxl,
                        input int mid_at, input logic exp_acc, input longint exp_expo,
                        input string tag);
    int n;
    int lat;
    ord_kind   = k;
    ord_client = CW'(c);
    ord_amount = LW'(amt);
    ord_valid  = 1'b1;
    n = 0;
    while (!ord_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, longint'(ord_ready), 1);
    @(negedge clk);
    ord_valid  = 1'b0;
    lat        = 1;
    cxl_client = CW'(c);
    cxl_amount = AW'(mid_cxl);
    cxl_valid  = (mid_at == lat);
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
      cxl_valid = (mid_at == lat);
    end
    chk({tag, " latency"}, longint'(lat), 2);
    chk({tag, " accept"}, longint'(rsp_accept), longint'(exp_acc));
    chk({tag, " client"}, longint'(rsp_client), longint'(c));
    chk({tag, " exposure"}, longint'(rsp_exposure), exp_expo);
    if (cxl_valid) begin
      @(negedge clk);
      cxl_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rdy_seen;
    logic [11:0] rsp_seen;
    longint      acc_model;
    int          seen;

    //           kind  c  amount pre mid at acc  expo
    vecs[0]  = '{1'b0, 3, 1,     0,  0,  0, 1'b0, 1};
    vecs[1]  = '{1'b0, 3, 0,     0,  0,  0, 1'b1, 0};
    vecs[2]  = '{1'b1, 5, 100,   0,  0,  0, 1'b1, 0};
    vecs[3]  = '{1'b0, 5, 60,    0,  0,  0, 1'b1, 60};
    vecs[4]  = '{1'b0, 5, 50,    0,  0,  0, 1'b0, 110};
    vecs[5]  = '{1'b1, 5, 100,   0,  0,  0, 1'b1, 60};
    vecs[6]  = '{1'b0, 5, 70,    30, 0,  0, 1'b1, 100};
    vecs[7]  = '{1'b0, 5, 1,     0,  0,  0, 1'b0, 101};
    vecs[8]  = '{1'b0, 5, 20,    20, 15, 2, 1'b1, 100};
    vecs[9]  = '{1'b0, 5, 15,    0,  0,  0, 1'b1, 100};
    vecs[10] = '{1'b1, 5, 200,   0,  0,  0, 1'b1, 100};
    vecs[11] = '{1'b1, 6, 50,    0,  0,  0, 1'b1, 0};
    vecs[12] = '{1'b0, 6, 40,    0,  30, 1, 1'b1, 40};
    vecs[13] = '{1'b0, 6, 20,    0,  0,  0, 1'b1, 30};
    vecs[14] = '{1'b0, 6, 0,     100, 0, 0, 1'b1, 0};

    HRESETn    = 1'b1;
    ord_valid  = 1'b0;
    ord_kind   = 1'b0;
    ord_client = '0;
    ord_amount = '0;
    cxl_valid  = 1'b0;
    cxl_client = '0;
    cxl_amount = '0;
    repeat (3) @(negedge clk);
    HRESETn = 1'b0;

    chk("reset ord_ready", longint'(ord_ready), 1);
    chk("reset rsp_valid", longint'(rsp_valid), 0);
    chk("reset rsp_accept", longint'(rsp_accept), 0);
    chk("reset rsp_client", longint'(rsp_client), 0);
    chk("reset rsp_exposure", longint'(rsp_exposure), 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].pre_cxl != 0) pulse_cxl(vecs[i].client, vecs[i].pre_cxl);
      do_req(vecs[i].kind, vecs[i].client, vecs[i].amount, vecs[i].mid_cxl, vecs[i].mid_at,
             vecs[i].exp_acc, vecs[i].exp_expo, $sformatf("vec%0d", i));
      $display("vec%0d kind=%0d client=%0d amount=%0d -> accept=%0d exposure=%0d",
               i, vecs[i].kind, vecs[i].client, vecs[i].amount, rsp_accept, rsp_exposure);
    end

    // Back-to-back requests: ord_valid stays high across twelve cycles.
    @(negedge clk);
    ord_kind   = 1'b0;
    ord_client = CW'(1);
    ord_amount = '0;
    ord_valid  = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rdy_seen[i] = ord_ready;
      rsp_seen[i] = rsp_valid;
      @(negedge clk);
    end
    ord_valid = 1'b0;
    chk("stream ready pattern", longint'(rdy_seen), longint'(12'h249));
    chk("stream rsp pattern", longint'(rsp_seen), longint'(12'h924));
    $display("stream ready=%03h rsp=%03h", rdy_seen, rsp_seen);

    // Saturation on client 7 with an all-ones limit.
    do_req(1'b1, 7, ONES, 0, 0, 1'b1, 0, "sat max");
    acc_model = 0;
    for (int i = 0; i < 17; i++) begin
      acc_model = acc_model + 65535;
      if (acc_model > ONES) acc_model = ONES;
      do_req(1'b0, 7, 65535, 0, 0, 1'b1, acc_model, $sformatf("sat ord%0d", i));
      $display("sat ord%0d exposure=%0d", i, rsp_exposure);
    end
    do_req(1'b0, 7, 1, 0, 0, 1'b1, ONES, "sat hold");
    do_req(1'b1, 7, ONES - 1, 0, 0, 1'b1, ONES, "sat max lower");
    do_req(1'b0, 7, 1, 0, 0, 1'b0, ONES, "sat no wrap");
    $display("sat final reject exposure=%0d", rsp_exposure);

    // Reset asserted while a request is in CHECK.
    ord_kind   = 1'b0;
    ord_client = CW'(5);
    ord_amount = LW'(1);
    ord_valid  = 1'b1;
    seen = 0;
    while (!ord_ready && seen < 8) begin
      @(negedge clk);
      seen++;
    end
    @(negedge clk);
    ord_valid = 1'b0;
    HRESETn   = 1'b1;
    @(negedge clk);
    HRESETn = 1'b0;
    chk("abort ord_ready", longint'(ord_ready), 1);
    chk("abort rsp_exposure", longint'(rsp_exposure), 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("abort no rsp_valid", longint'(seen), 0);
    $display("abort: responses seen after reset in CHECK = %0d", seen);
    do_req(1'b0, 5, 1, 0, 0, 1'b0, 1, "post reset c5");
    do_req(1'b0, 7, 0, 0, 0, 1'b1, 0, "post reset c7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
